// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package mole_pkg;

  typedef enum logic [1:0] {StIdle, StGap, StShow} mole_state_e;

  localparam int unsigned DefNumMoles = 3;
  localparam int unsigned DefCntW     = 28;
  localparam int unsigned DefScoreW   = 8;
  localparam logic [7:0]  DefLfsrSeed = 8'hA5;

  // Feedback taps at stages 8,6,5,4 of an 8-bit Fibonacci LFSR.
  localparam logic [7:0]  LfsrTapMask = 8'hB8;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit maximal-length LFSR used to pick which mole lights next.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LfsrTapMask)};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game controller: lights one mole per round, scores hits and
// wrong presses, and counts moles that time out.
module mole_game_core
  import mole_pkg::*;
#(
  parameter int unsigned NUM_MOLES = DefNumMoles,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned SCORE_W   = DefScoreW,
  parameter logic [7:0]  LFSR_SEED = DefLfsrSeed
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 game,
  input  logic [CNT_W-1:0]     speed,
  input  logic [NUM_MOLES-1:0] buttons,
  output logic [NUM_MOLES-1:0] moles,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 hit,
  output logic                 busy
);

  mole_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_MOLES-1:0] moles_q, moles_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   misses_q, misses_d;
  logic                 hit_q, hit_d;
  logic [NUM_MOLES-1:0] btn_q;
  logic                 game_q;
  logic                 armed_q;

  logic [7:0]           lfsr;
  logic [7:0]           idx;
  logic [NUM_MOLES-1:0] pick;
  logic [NUM_MOLES-1:0] edges;
  logic                 lit_edge, unlit_edge, game_rise;
  logic [CNT_W-1:0]     reload;
  logic [SCORE_W-1:0]   score_inc, score_dec, misses_inc;

  mole_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .value (lfsr)
  );

  assign idx        = lfsr % 8'(NUM_MOLES);
  assign edges      = buttons & ~btn_q;
  assign lit_edge   = |(edges & moles_q);
  assign unlit_edge = |(edges & ~moles_q);
  // armed_q masks the first cycle after reset, so a game level already high
  // during reset is not mistaken for a fresh start.
  assign game_rise  = game & ~game_q & armed_q;
  assign reload     = (speed == '0) ? '0 : speed - CNT_W'(1);
  assign score_inc  = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
  assign score_dec  = (score_q == '0) ? score_q : score_q - SCORE_W'(1);
  assign misses_inc = (misses_q == {SCORE_W{1'b1}}) ? misses_q : misses_q + SCORE_W'(1);

  always_comb begin
    pick = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      pick[i] = (idx == 8'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    moles_d  = moles_q;
    score_d  = score_q;
    misses_d = misses_q;
    hit_d    = 1'b0;
    if (!game) begin
      state_d = StIdle;
      moles_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          moles_d = '0;
          if (game_rise) begin
            score_d  = '0;
            misses_d = '0;
            state_d  = StGap;
            cnt_d    = reload;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_d = StShow;
            moles_d = pick;
            cnt_d   = reload;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StShow: begin
          // Any wrong press penalises and also disqualifies a same-cycle hit.
          if (unlit_edge) begin
            score_d = score_dec;
          end
          if (lit_edge && !unlit_edge) begin
            score_d = score_inc;
            hit_d   = 1'b1;
            moles_d = '0;
            state_d = StGap;
            cnt_d   = reload;
          end else if (cnt_q == '0) begin
            misses_d = misses_inc;
            moles_d  = '0;
            state_d  = StGap;
            cnt_d    = reload;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          moles_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      moles_q  <= '0;
      score_q  <= '0;
      misses_q <= '0;
      hit_q    <= 1'b0;
      btn_q    <= '0;
      game_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      moles_q  <= moles_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      hit_q    <= hit_d;
      btn_q    <= buttons;
      game_q   <= game;
      armed_q  <= 1'b1;
    end
  end

  assign moles  = moles_q;
  assign score  = score_q;
  assign misses = misses_q;
  assign hit    = hit_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_mole_game_core.sv
// Randomised and directed bench for mole_game_core (five moles) against a
// phase/remaining-cycles reference model.
module tb_mole_game_core;

  localparam int N  = 5;
  localparam int CW = 28;
  localparam int SW = 8;

  localparam int PIdle = 0;
  localparam int PGap  = 1;
  localparam int PShow = 2;

  logic          clock;
  logic          reset;
  logic          game;
  logic [CW-1:0] speed;
  logic [N-1:0]  buttons;
  logic [N-1:0]  moles;
  logic [SW-1:0] score;
  logic [SW-1:0] misses;
  logic          hit;
  logic          busy;

  mole_game_core #(
    .NUM_MOLES (N),
    .CNT_W     (CW),
    .SCORE_W   (SW),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .game    (game),
    .speed   (speed),
    .buttons (buttons),
    .moles   (moles),
    .score   (score),
    .misses  (misses),
    .hit     (hit),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passes = 0;
  int total  = 0;
  logic [N-1:0] seen = '0;

  // Reference model state
  int         m_phase, m_remain, m_score, m_misses, m_appear;
  logic       m_hit, m_gprev, m_armed;
  logic [N-1:0] m_moles, m_prevb;
  logic [7:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int plen(input logic [CW-1:0] s);
    return (s == '0) ? 1 : int'(s);
  endfunction

  task automatic to_gap();
    m_moles  = '0;
    m_phase  = PGap;
    m_remain = plen(speed);
  endtask

  task automatic model_step();
    logic [N-1:0] e;
    logic right, wrong;
    if (reset) begin
      m_phase = PIdle; m_remain = 0; m_moles = '0; m_score = 0; m_misses = 0;
      m_hit = 1'b0; m_prevb = '0; m_gprev = 1'b0; m_armed = 1'b0; m_lfsr = 8'hA5;
      return;
    end
    m_hit = 1'b0;
    e = buttons & ~m_prevb;
    if (!game) begin
      m_phase = PIdle;
      m_moles = '0;
    end else begin
      case (m_phase)
        PIdle: if (!m_gprev && m_armed) begin
          m_score = 0; m_misses = 0; to_gap();
        end
        PGap: begin
          m_remain--;
          if (m_remain == 0) begin
            m_phase  = PShow;
            m_remain = plen(speed);
            m_moles  = N'(1 << (int'(m_lfsr) % N));
            m_appear++;
          end
        end
        default: begin
          wrong = |(e & ~m_moles);
          right = |(e & m_moles);
          if (wrong) m_score = (m_score == 0) ? 0 : m_score - 1;
          if (right && !wrong) begin
            m_score = (m_score == 255) ? 255 : m_score + 1;
            m_hit = 1'b1;
            to_gap();
          end else begin
            m_remain--;
            if (m_remain == 0) begin
              m_misses = (m_misses == 255) ? 255 : m_misses + 1;
              to_gap();
            end
          end
        end
      endcase
    end
    m_prevb = buttons;
    m_gprev = game;
    m_armed = 1'b1;
    m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  initial begin
    m_appear = 0;
    forever begin
      @(posedge clock or posedge reset);
      model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock);
      check("moles",  32'(moles),  32'(m_moles));
      check("score",  32'(score),  32'(m_score));
      check("misses", 32'(misses), 32'(m_misses));
      check("hit",    32'(hit),    32'(m_hit));
      check("busy",   32'(busy),   32'(m_phase != PIdle));
      check("onehot0", 32'($onehot0(moles)), 32'd1);
      seen = seen | moles;
    end
  end

  task automatic wait_show();
    int k;
    k = 0;
    while (m_moles == '0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (m_moles == '0) begin
      total++;
      $display("FAIL wait_show: no mole lit within %0d cycles", k);
    end
  endtask

  task automatic do_hit();
    wait_show();
    buttons = m_moles;
    @(negedge clock);
    check("hit_pulse", 32'(hit), 32'd1);
    buttons = '0;
    @(negedge clock);
  endtask

  initial begin
    int n;
    int r;
    logic [N-1:0] w;
    reset = 1'b1; game = 1'b0; speed = CW'(4); buttons = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_moles",  32'(moles),  32'd0);
    check("rst_score",  32'(score),  32'd0);
    check("rst_misses", 32'(misses), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_hit",    32'(hit),    32'd0);
    @(negedge clock);
    game = 1'b1;

    // speed 4, no presses: 4 dark, 4 lit, then dark with one miss
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("gap_dark", 32'(moles), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("show_lit", 32'($onehot(moles)), 32'd1);
    end
    @(negedge clock);
    check("timeout_dark", 32'(moles), 32'd0);
    check("first_miss", 32'(misses), 32'd1);

    // speed 10, hit three cycles into the show, then a 10-cycle gap
    speed = CW'(10);
    wait_show();
    repeat (3) @(negedge clock);
    buttons = m_moles;
    @(negedge clock);
    check("hit10_pulse", 32'(hit), 32'd1);
    check("hit10_score", 32'(score), 32'd1);
    check("hit10_dark", 32'(moles), 32'd0);
    buttons = '0;
    n = 0;
    repeat (40) begin
      @(negedge clock);
      if (moles != '0) break;
      n++;
    end
    check("gap_after_hit", 32'(n), 32'd9);

    // score 2, then three wrong presses
    buttons = m_moles;
    @(negedge clock);
    check("score_two", 32'(score), 32'd2);
    buttons = '0;
    wait_show();
    w = m_moles[0] ? N'(2) : N'(1);
    buttons = w;
    @(negedge clock);
    check("wrong1_score", 32'(score), 32'd1);
    check("wrong1_lit", 32'($onehot(moles)), 32'd1);
    buttons = '0; @(negedge clock);
    buttons = w;  @(negedge clock);
    check("wrong2_score", 32'(score), 32'd0);
    buttons = '0; @(negedge clock);
    buttons = w;  @(negedge clock);
    check("wrong3_score", 32'(score), 32'd0);
    check("wrong3_nohit", 32'(hit), 32'd0);
    buttons = '0;

    // game dropped mid-show with score 5
    speed = CW'(2);
    repeat (5) do_hit();
    check("score_five", 32'(score), 32'd5);
    wait_show();
    game = 1'b0;
    @(negedge clock);
    check("drop_moles", 32'(moles), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_score", 32'(score), 32'd5);
    game = 1'b1;
    @(negedge clock);
    check("restart_score", 32'(score), 32'd0);
    check("restart_misses", 32'(misses), 32'd0);

    // saturation at 255, then lit+unlit together
    speed = CW'(1);
    repeat (255) do_hit();
    check("score_255", 32'(score), 32'd255);
    do_hit();
    check("score_sat", 32'(score), 32'd255);
    wait_show();
    w = m_moles[0] ? N'(2) : N'(1);
    buttons = m_moles | w;
    @(negedge clock);
    check("both_nohit", 32'(hit), 32'd0);
    check("both_score", 32'(score), 32'd254);
    buttons = '0;

    // speed 0 acts as 1
    speed = '0;
    for (int i = 0; i < 2; i++) begin
      wait_show();
      @(negedge clock);
      check("speed0_show", 32'(moles), 32'd0);
      @(negedge clock);
      check("speed0_gap", 32'($onehot(moles)), 32'd1);
    end

    // asynchronous reset mid-show; stays idle with game held high
    speed = CW'(5);
    wait_show();
    #2 reset = 1'b1;
    #1;
    check("async_moles", 32'(moles), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("idle_after_reset", 32'(busy), 32'd0);

    // randomised play
    game = 1'b0;
    @(negedge clock);
    game = 1'b1;
    speed = CW'(1);
    for (int c = 0; c < 8000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 49) == 0) speed = CW'($urandom_range(0, 2));
      if (!game) game = 1'b1;
      else if ($urandom_range(0, 499) == 0) game = 1'b0;
      r = int'($urandom_range(0, 9));
      if (r < 3 && m_moles != '0) buttons = m_moles;
      else if (r < 5) buttons = N'($urandom_range(0, 31));
      else buttons = '0;
    end
    buttons = '0;
    @(negedge clock);
    check("all_idx_seen", 32'(seen), 32'h1f);
    check("appearances", 32'(m_appear >= 1000), 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
